fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the program counter register at the front of the 5-stage RISC-V pipeline.
- Generates the PC next value and enable, and sequences the instruction-memory request handshake.
- Applies hazard-unit stalls and EX-stage branch/jump redirects.
- Drives the IF/ID valid and flush controls and keeps a retired-fetch counter.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, redirect address for a misaligned target (optional feature only).
- CNT_W, 32, width of fetch_count_o.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- pc_q_i  in  32  current PC register value.
- pc_next_o  out  32  value loaded into the PC register.
- pc_en_o  out  1  PC register clock enable.
- stall_i  in  1  hazard-unit stall (load-use); holds the PC.
- redirect_valid_i  in  1  EX-stage taken branch/jump, 1-cycle pulse.
- redirect_target_i  in  32  redirect target address.
- imem_req_o  out  1  instruction-memory request, address = pc_q_i.
- imem_ready_i  in  1  instruction word valid this cycle.
- if_valid_o  out  1  IF/ID register captures a valid instruction.
- flush_ifid_o  out  1  invalidate IF/ID contents.
- fetch_count_o  out  CNT_W  number of instructions delivered (if_valid_o count).

Behaviour:
- Reset (async, rst_n=1):
  - state=BOOT, pending_target=0, fetch_count_o=0.
  - All 1-bit outputs 0; pc_next_o=RESET_VECTOR.
- States: BOOT, FETCH, DRAIN. All outputs are combinational from state and inputs; only state, pending_target and the counter are registered.
- BOOT:
  - pc_en_o=1, pc_next_o=RESET_VECTOR, imem_req_o=0.
  - Next state FETCH. The PC equals RESET_VECTOR in the first FETCH cycle.
  - redirect_valid_i and stall_i are ignored in BOOT.
- FETCH:
  - imem_req_o=1 every cycle. Priority is redirect > stall > normal.
  - Redirect with imem_ready_i=1:
    - pc_en_o=1, pc_next_o=redirect_target_i, if_valid_o=0, flush_ifid_o=1.
    - Stay in FETCH.
  - Redirect with imem_ready_i=0:
    - flush_ifid_o=1, pc_en_o=0, pending_target<=redirect_target_i.
    - Next state DRAIN.
  - Stall with imem_ready_i=1: pc_en_o=0, if_valid_o=0. The same address is re-requested next cycle.
  - Normal, imem_ready_i=1 and no stall:
    - pc_en_o=1, pc_next_o=pc_q_i+4, if_valid_o=1, fetch_count_o increments.
    - pc_q_i+4 wraps modulo 2^32, so 32'hFFFF_FFFC goes to 0.
  - imem_ready_i=0 without redirect: pc_en_o=0, if_valid_o=0, request held.
- DRAIN: an outstanding fetch is discarded.
  - imem_req_o=1, if_valid_o=0.
  - A new redirect in DRAIN overwrites pending_target and asserts flush_ifid_o again.
  - On imem_ready_i=1:
    - pc_en_o=1, pc_next_o=pending_target, or redirect_target_i if a redirect is present the same cycle.
    - Next state FETCH.
  - stall_i is ignored in DRAIN.
- Invariants:
  - if_valid_o and flush_ifid_o are never both 1.
  - pc_en_o=0 whenever pc_next_o is not meaningful.
- fetch_count_o wraps to 0 on overflow.
- Reset during DRAIN discards pending_target and returns to BOOT.

Optional Feature:
- Macro FETCH_SEQ_MISALIGN_TRAP_EN.
- When defined:
  - Adds outputs trap_o (1, pulse) and trap_epc_o (32, registered, reset 0).
  - Any applied redirect target with bits[1:0]!=0 loads TRAP_VECTOR instead and pulses trap_o the cycle pc_en_o loads it.
  - trap_epc_o captures the offending target in that same cycle.
- When not defined: the ports are absent, and redirect targets have bits[1:0] forced to 2'b00 before use.

Test Plan:
1. Reset, then imem_ready_i=1 constant:
   - BOOT loads 0.
   - The following cycles show pc_next_o 4, 8, 12 with if_valid_o=1.
   - fetch_count_o=3 after 3 fetch cycles.
2. stall_i=1 for 2 cycles at PC=0x10: pc_en_o=0 and if_valid_o=0 for both cycles, imem_req_o stays 1, then pc_next_o=0x14 and fetching resumes.
3. Redirect to 0x200 with imem_ready_i=1 and stall_i=1 at the same time: flush_ifid_o=1, pc_next_o=0x200, pc_en_o=1. Redirect beats stall.
4. Redirect to 0x300 while imem_ready_i=0:
   - State goes to DRAIN.
   - A ready 3 cycles later gives if_valid_o=0, pc_next_o=0x300.
   - A second redirect to 0x400 during DRAIN makes 0x400 win.
5. PC=0xFFFF_FFFC with ready: pc_next_o=0. Assert rst_n mid-DRAIN: outputs clear immediately, then the BOOT sequence restarts at RESET_VECTOR.
6. Redirect to 0x102:
   - With the macro: pc_next_o=0x100, trap_o=1, trap_epc_o=0x102.
   - Without the macro: pc_next_o=0x100, no trap.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC/fetch sequencing for the IF stage (optional FETCH_SEQ_MISALIGN_TRAP_EN)
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
`endif
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc_q_i,
    output logic [31:0]      pc_next_o,
    output logic             pc_en_o,
    input  logic             stall_i,
    input  logic             redirect_valid_i,
    input  logic [31:0]      redirect_target_i,
    output logic             imem_req_o,
    input  logic             imem_ready_i,
    output logic             if_valid_o,
    output logic             flush_ifid_o,
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    output logic             trap_o,
    output logic [31:0]      trap_epc_o,
`endif
    output logic [CNT_W-1:0] fetch_count_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pending_target;
    logic        pending_load;
    logic [31:0] target_in;
    logic [31:0] target_sel;
    logic [31:0] target_apply;
    logic        target_load;
    logic        misaligned;

    // Without the trap, misaligned targets are silently word-aligned on entry.
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    assign target_in    = redirect_target_i;
    assign misaligned   = |target_sel[1:0];
    assign target_apply = misaligned ? TRAP_VECTOR : target_sel;
`else
    assign target_in    = redirect_target_i & 32'hFFFF_FFFC;
    assign misaligned   = 1'b0;
    assign target_apply = target_sel;
`endif

    assign target_sel = (state == DRAIN && !redirect_valid_i) ? pending_target : target_in;

    always_comb begin
        state_next   = state;
        pc_next_o    = RESET_VECTOR;
        pc_en_o      = 1'b0;
        imem_req_o   = 1'b0;
        if_valid_o   = 1'b0;
        flush_ifid_o = 1'b0;
        pending_load = 1'b0;
        target_load  = 1'b0;
        if (!rst_n) begin
            case (state)
                BOOT: begin
                    pc_en_o    = 1'b1;
                    pc_next_o  = RESET_VECTOR;
                    state_next = FETCH;
                end
                FETCH: begin
                    imem_req_o = 1'b1;
                    pc_next_o  = pc_q_i;
                    if (redirect_valid_i) begin
                        flush_ifid_o = 1'b1;
                        if (imem_ready_i) begin
                            pc_en_o     = 1'b1;
                            pc_next_o   = target_apply;
                            target_load = 1'b1;
                        end else begin
                            pending_load = 1'b1;
                            state_next   = DRAIN;
                        end
                    end else if (imem_ready_i && !stall_i) begin
                        pc_en_o    = 1'b1;
                        pc_next_o  = pc_q_i + 32'd4;
                        if_valid_o = 1'b1;
                    end
                end
                DRAIN: begin
                    imem_req_o = 1'b1;
                    pc_next_o  = pc_q_i;
                    if (redirect_valid_i) begin
                        flush_ifid_o = 1'b1;
                        pending_load = 1'b1;
                    end
                    // The in-flight word is dropped; load whichever target is newest.
                    if (imem_ready_i) begin
                        pc_en_o     = 1'b1;
                        pc_next_o   = target_apply;
                        target_load = 1'b1;
                        state_next  = FETCH;
                    end
                end
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state          <= BOOT;
            pending_target <= 32'h0;
            fetch_count_o  <= '0;
        end else begin
            state <= state_next;
            if (pending_load) begin
                pending_target <= target_in;
            end
            if (if_valid_o) begin
                fetch_count_o <= fetch_count_o + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    assign trap_o = target_load & misaligned;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            trap_epc_o <= 32'h0;
        end else if (trap_o) begin
            trap_epc_o <= target_sel;
        end
    end
`else
    logic unused_misc;
    assign unused_misc = target_load & misaligned;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic        if_valid;
    logic        flush_ifid;
    logic [31:0] fetch_count;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    logic        trap;
    logic [31:0] trap_epc;
    localparam logic TRAP_EXP = 1'b1;
`else
    localparam logic TRAP_EXP = 1'b0;
`endif

    fetch_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_q_i            (pc_q),
        .pc_next_o         (pc_next),
        .pc_en_o           (pc_en),
        .stall_i           (stall),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .imem_req_o        (imem_req),
        .imem_ready_i      (imem_ready),
        .if_valid_o        (if_valid),
        .flush_ifid_o      (flush_ifid),
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
        .trap_o            (trap),
        .trap_epc_o        (trap_epc),
`endif
        .fetch_count_o     (fetch_count)
    );

    always #5 clk = ~clk;

    // External PC register that the sequencer controls.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) pc_q <= 32'h0;
        else if (pc_en) pc_q <= pc_next;
    end

    typedef struct {
        string       name;
        logic        en;
        logic [31:0] nxt;
        logic        chk_nxt;
        logic        req;
        logic        vld;
        logic        fl;
        logic [31:0] cnt;
        logic        trp;
        logic [31:0] epc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_cnt = 32'h0;
    logic [31:0] exp_epc = 32'h0;
    bit          done = 1'b0;

    task automatic cmp(input string name, input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", name, what, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "pc_en", {31'h0, pc_en}, {31'h0, e.en});
            if (e.chk_nxt) cmp(e.name, "pc_next", pc_next, e.nxt);
            cmp(e.name, "imem_req", {31'h0, imem_req}, {31'h0, e.req});
            cmp(e.name, "if_valid", {31'h0, if_valid}, {31'h0, e.vld});
            cmp(e.name, "flush", {31'h0, flush_ifid}, {31'h0, e.fl});
            cmp(e.name, "count", fetch_count, e.cnt);
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
            cmp(e.name, "trap", {31'h0, trap}, {31'h0, e.trp});
            cmp(e.name, "trap_epc", trap_epc, e.epc);
`endif
        end
    end

    task automatic cyc(input string name, input logic rst, input logic stl, input logic rv,
                       input logic [31:0] rt, input logic rdy, input logic e_en,
                       input logic [31:0] e_nxt, input logic e_req, input logic e_vld,
                       input logic e_fl, input logic e_trp);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        stall = stl;
        redirect_valid = rv;
        redirect_target = rt;
        imem_ready = rdy;
        if (rst) begin
            exp_cnt = 32'h0;
            exp_epc = 32'h0;
        end
        e.name = name;
        e.en = e_en;
        e.nxt = e_nxt;
        e.chk_nxt = e_en | rst;
        e.req = e_req;
        e.vld = e_vld;
        e.fl = e_fl;
        e.cnt = exp_cnt;
        e.trp = e_trp;
        e.epc = exp_epc;
        sb.push_back(e);
        if (e_vld) exp_cnt = exp_cnt + 32'd1;
        if (e_trp) exp_epc = rt;
    endtask

    initial begin
        //   name          rst stl rv  target        rdy en  next          req vld fl  trap
        cyc("reset",       1,  0,  0,  32'h0,        1,  0,  32'h0,        0,  0,  0,  0);
        cyc("boot",        0,  0,  0,  32'h0,        1,  1,  32'h0,        0,  0,  0,  0);
        cyc("fetch0",      0,  0,  0,  32'h0,        1,  1,  32'h4,        1,  1,  0,  0);
        cyc("fetch4",      0,  0,  0,  32'h0,        1,  1,  32'h8,        1,  1,  0,  0);
        cyc("fetch8",      0,  0,  0,  32'h0,        1,  1,  32'hC,        1,  1,  0,  0);
        cyc("fetchC",      0,  0,  0,  32'h0,        1,  1,  32'h10,       1,  1,  0,  0);
        cyc("stall1",      0,  1,  0,  32'h0,        1,  0,  32'h0,        1,  0,  0,  0);
        cyc("stall2",      0,  1,  0,  32'h0,        1,  0,  32'h0,        1,  0,  0,  0);
        cyc("resume10",    0,  0,  0,  32'h0,        1,  1,  32'h14,       1,  1,  0,  0);
        cyc("redir_stall", 0,  1,  1,  32'h200,      1,  1,  32'h200,      1,  0,  1,  0);
        cyc("fetch200",    0,  0,  0,  32'h0,        1,  1,  32'h204,      1,  1,  0,  0);
        cyc("redir_nordy", 0,  0,  1,  32'h300,      0,  0,  32'h0,        1,  0,  1,  0);
        cyc("drain1",      0,  0,  0,  32'h0,        0,  0,  32'h0,        1,  0,  0,  0);
        cyc("drain2",      0,  1,  0,  32'h0,        0,  0,  32'h0,        1,  0,  0,  0);
        cyc("drain_done",  0,  0,  0,  32'h0,        1,  1,  32'h300,      1,  0,  0,  0);
        cyc("fetch300",    0,  0,  0,  32'h0,        1,  1,  32'h304,      1,  1,  0,  0);
        cyc("redir500",    0,  0,  1,  32'h500,      0,  0,  32'h0,        1,  0,  1,  0);
        cyc("redir400",    0,  0,  1,  32'h400,      0,  0,  32'h0,        1,  0,  1,  0);
        cyc("drain_400",   0,  0,  0,  32'h0,        1,  1,  32'h400,      1,  0,  0,  0);
        cyc("redir700",    0,  0,  1,  32'h700,      0,  0,  32'h0,        1,  0,  1,  0);
        cyc("drain_same",  0,  0,  1,  32'h404,      1,  1,  32'h404,      1,  0,  1,  0);
        cyc("redir_top",   0,  0,  1,  32'hFFFF_FFFC,1,  1,  32'hFFFF_FFFC,1,  0,  1,  0);
        cyc("wrap",        0,  0,  0,  32'h0,        1,  1,  32'h0,        1,  1,  0,  0);
        cyc("redir600",    0,  0,  1,  32'h600,      0,  0,  32'h0,        1,  0,  1,  0);
        cyc("rst_drain",   1,  0,  0,  32'h0,        1,  0,  32'h0,        0,  0,  0,  0);
        cyc("reboot",      0,  0,  0,  32'h0,        1,  1,  32'h0,        0,  0,  0,  0);
        cyc("refetch0",    0,  0,  0,  32'h0,        1,  1,  32'h4,        1,  1,  0,  0);
        cyc("misalign",    0,  0,  1,  32'h102,      1,  1,  32'h100,      1,  0,  1,  TRAP_EXP);
        cyc("fetch100",    0,  0,  0,  32'h0,        1,  1,  32'h104,      1,  1,  0,  0);
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_queue actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
